// File: rtl/spram_pkg.sv
// Shared types for the single-port RAM and its FIFO controller.
package spram_pkg;

    localparam int SPRAM_DATA_BITS = 8;

    typedef enum logic {
        SPRAM_READ  = 1'b0,
        SPRAM_WRITE = 1'b1
    } spram_mode_e;

    typedef enum logic {
        SFIFO_IDLE    = 1'b0,
        SFIFO_RD_WAIT = 1'b1
    } spram_fifo_state_e;

endpackage

// File: rtl/spram.sv
// Single-port RAM: one operation per cycle, write or registered read.
module spram
    import spram_pkg::*;
#(
    parameter int SIZE      = 32,
    parameter int DATA_BITS = SPRAM_DATA_BITS,
    parameter int ADDR_BITS = $clog2(SIZE)
) (
    input  logic                 clk,
    input  spram_mode_e          mode,
    input  logic [ADDR_BITS-1:0] rd_addr,
    input  logic [ADDR_BITS-1:0] wr_addr,
    input  logic [DATA_BITS-1:0] data_wr,
    output logic [DATA_BITS-1:0] data_rd
);

    logic [DATA_BITS-1:0] mem_q [SIZE];
    logic [DATA_BITS-1:0] data_rd_q;

    always_ff @(posedge clk) begin
        if (mode == SPRAM_WRITE) begin
            mem_q[wr_addr] <= data_wr;
        end else begin
            data_rd_q <= mem_q[rd_addr];
        end
    end

    assign data_rd = data_rd_q;

endmodule

// File: rtl/spram_fifo.sv
// FIFO controller over the single-port spram with a first-word-fall-through output register.
// Optional SPRAM_FIFO_BYPASS_EN: a push into an empty, idle FIFO loads the output register directly.
module spram_fifo
    import spram_pkg::*;
#(
    parameter int DEPTH     = 32,
    parameter int DATA_BITS = 8,
    parameter int ADDR_BITS = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push_valid,
    output logic                 push_ready,
    input  logic [DATA_BITS-1:0] push_data,
    output logic                 pop_valid,
    input  logic                 pop_ready,
    output logic [DATA_BITS-1:0] pop_data,
    output logic [ADDR_BITS:0]   count
);

    localparam logic [ADDR_BITS-1:0] PTR_LAST  = ADDR_BITS'(DEPTH - 1);
    localparam logic [ADDR_BITS:0]   CNT_DEPTH = (ADDR_BITS + 1)'(DEPTH);

    spram_fifo_state_e    state_q, state_d;
    logic [ADDR_BITS-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_BITS-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_BITS:0]   ram_count_q, ram_count_d;
    logic                 out_valid_q, out_valid_d;
    logic [DATA_BITS-1:0] out_data_q, out_data_d;

    spram_mode_e          mode;
    logic [ADDR_BITS-1:0] rd_addr;
    logic [ADDR_BITS-1:0] wr_addr;
    logic [DATA_BITS-1:0] data_wr;
    logic [DATA_BITS-1:0] data_rd;

    logic read_issue;
    logic push_fire;
    logic pop_fire;
    logic bypass;

    function automatic logic [ADDR_BITS-1:0] ptr_inc(input logic [ADDR_BITS-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    spram #(
        .SIZE      (DEPTH),
        .DATA_BITS (DATA_BITS)
    ) u_spram (
        .clk     (clk),
        .mode    (mode),
        .rd_addr (rd_addr),
        .wr_addr (wr_addr),
        .data_wr (data_wr),
        .data_rd (data_rd)
    );

    // The in-flight read word is counted in neither ram_count nor out_valid.
    always_comb begin
        count      = ram_count_q + (ADDR_BITS + 1)'(out_valid_q);
        read_issue = (state_q == SFIFO_IDLE) && (ram_count_q != '0) && !out_valid_q;
        push_ready = (count < CNT_DEPTH) && !read_issue;
        push_fire  = push_valid && push_ready;
        pop_fire   = out_valid_q && pop_ready;
`ifdef SPRAM_FIFO_BYPASS_EN
        bypass     = push_fire && (count == '0) && (state_q == SFIFO_IDLE);
`else
        bypass     = 1'b0;
`endif
    end

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        ram_count_d = ram_count_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        mode        = SPRAM_READ;
        rd_addr     = rd_ptr_q;
        wr_addr     = wr_ptr_q;
        data_wr     = push_data;

        case (state_q)
            SFIFO_IDLE: begin
                if (read_issue) begin
                    rd_ptr_d    = ptr_inc(rd_ptr_q);
                    ram_count_d = ram_count_q - 1'b1;
                    state_d     = SFIFO_RD_WAIT;
                end
            end
            SFIFO_RD_WAIT: begin
                out_data_d  = data_rd;
                out_valid_d = 1'b1;
                state_d     = SFIFO_IDLE;
            end
            default: state_d = SFIFO_IDLE;
        endcase

        if (pop_fire) begin
            out_valid_d = 1'b0;
        end

        // push_ready is low during a read issue, so a RAM write never collides with it.
        if (bypass) begin
            out_data_d  = push_data;
            out_valid_d = 1'b1;
        end else if (push_fire) begin
            mode        = SPRAM_WRITE;
            wr_ptr_d    = ptr_inc(wr_ptr_q);
            ram_count_d = ram_count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= SFIFO_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            ram_count_q <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            ram_count_q <= ram_count_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign pop_valid = out_valid_q;
    assign pop_data  = out_data_q;

endmodule

// File: tb/tb_spram_fifo.sv
// Directed bench for spram_fifo with a scoreboard queue and a small cycle model.
module tb_spram_fifo;
    import spram_pkg::*;

    localparam int DEPTH = 32;
    localparam int DW    = 8;
    localparam int AW    = $clog2(DEPTH);
`ifdef SPRAM_FIFO_BYPASS_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 3;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          push_valid = 1'b0;
    logic          pop_ready = 1'b0;
    logic [DW-1:0] push_data = '0;
    logic          push_ready;
    logic          pop_valid;
    logic [DW-1:0] pop_data;
    logic [AW:0]   count;

    spram_fifo #(.DEPTH(DEPTH), .DATA_BITS(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .push_valid (push_valid),
        .push_ready (push_ready),
        .push_data  (push_data),
        .pop_valid  (pop_valid),
        .pop_ready  (pop_ready),
        .pop_data   (pop_data),
        .count      (count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [DW-1:0] sb[$];
    int m_ram = 0;
    bit m_ov = 0, m_wait = 0;
    bit s_push, s_pv, s_wr;
    int n_pop = 0;
    int nv = 0;
    bit saw_wr_wrap = 0, saw_rd_wrap = 0;
    logic [AW-1:0] last_wr = '0, last_rd = '0;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: inputs already driven; sample and model at the falling edge.
    task automatic cyc();
        bit issue, pp, pf, byp;
        int tot;
        logic [DW-1:0] exp;
        logic [AW-1:0] cw, cr;
        @(negedge clk);
        tot   = m_ram + int'(m_ov);
        issue = !m_wait && !m_ov && (m_ram > 0);
        chk("push_ready", push_ready, (tot < DEPTH) && !issue);
        chk("pop_valid", pop_valid, m_ov);
        chk("count", count, tot);
        if (tot == DEPTH) chk("write_while_full", dut.mode == SPRAM_WRITE, 0);
        pp = push_valid && (tot < DEPTH) && !issue;
        pf = pop_ready && m_ov;
        s_push = pp;
        s_pv   = pop_valid;
        s_wr   = (dut.mode == SPRAM_WRITE);
        if (pf) begin
            chk("pop_has_entry", sb.size() != 0, 1);
            if (sb.size() != 0) begin
                exp = sb.pop_front();
                chk("pop_data", pop_data, exp);
                n_pop++;
            end
        end
        if (pp) sb.push_back(push_data);
`ifdef SPRAM_FIFO_BYPASS_EN
        byp = pp && (tot == 0) && !m_wait;
`else
        byp = 1'b0;
`endif
        if (issue) begin
            m_ram--;
            m_wait = 1'b1;
        end else if (m_wait) begin
            m_wait = 1'b0;
            m_ov   = 1'b1;
        end
        if (pf) m_ov = 1'b0;
        if (byp) m_ov = 1'b1;
        else if (pp) m_ram++;
        cw = dut.wr_ptr_q;
        cr = dut.rd_ptr_q;
        if (last_wr == AW'(DEPTH - 1) && cw == '0) saw_wr_wrap = 1'b1;
        if (last_rd == AW'(DEPTH - 1) && cr == '0) saw_rd_wrap = 1'b1;
        last_wr = cw;
        last_rd = cr;
        @(posedge clk);
        #1;
    endtask

    task automatic push_n(input int n, input int bound);
        int acc = 0;
        int k = 0;
        push_valid = 1'b1;
        while (acc < n && k < bound) begin
            push_data = DW'(nv);
            cyc();
            if (s_push) begin
                acc++;
                nv++;
            end
            k++;
        end
        push_valid = 1'b0;
        chk("push_n_accepted", acc, n);
    endtask

    task automatic drain(input int bound);
        int k = 0;
        push_valid = 1'b0;
        pop_ready  = 1'b1;
        while ((sb.size() != 0 || m_wait) && k < bound) begin
            cyc();
            k++;
        end
        chk("drain_done", sb.size(), 0);
        pop_ready = 1'b0;
        cyc();
    endtask

    initial begin
        int lat;

        // reset values
        #3;
        chk("rst_pop_valid", pop_valid, 0);
        chk("rst_pop_data", pop_data, 0);
        chk("rst_count", count, 0);
        chk("rst_push_ready", push_ready, 1);
        chk("rst_mode_read", dut.mode == SPRAM_READ, 1);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // latency from an empty FIFO
        push_valid = 1'b1;
        push_data  = 8'hA5;
        cyc();
        chk("lat_push_accept", s_push, 1);
`ifdef SPRAM_FIFO_BYPASS_EN
        chk("bypass_no_write", s_wr, 0);
`endif
        push_valid = 1'b0;
        lat = 0;
        s_pv = 1'b0;
        while (!s_pv && lat < 10) begin
            cyc();
            lat++;
        end
        chk("latency", lat, LAT);
        chk("lat_data", pop_data, 8'hA5);
        drain(20);

        // fill: offer 0..40 with the consumer stalled
        nv = 0;
        for (int k = 0; k < 80; k++) begin
            push_valid = (nv <= 40);
            push_data  = DW'(nv);
            cyc();
            if (s_push) nv++;
        end
        push_valid = 1'b0;
        chk("fill_accepted", nv, DEPTH);
        chk("fill_count", count, DEPTH);
        chk("fill_push_ready", push_ready, 0);

        // drain in order
        n_pop = 0;
        drain(200);
        chk("drain_pops", n_pop, DEPTH);
        chk("drain_count", count, 0);
        chk("drain_pop_valid", pop_valid, 0);

        // pointer wrap
        saw_wr_wrap = 1'b0;
        saw_rd_wrap = 1'b0;
        nv = 0;
        push_n(20, 60);
        drain(200);
        push_n(20, 60);
        drain(200);
        chk("wr_ptr_wrap", saw_wr_wrap, 1);
        chk("rd_ptr_wrap", saw_rd_wrap, 1);

        // concurrent push and pop from count=5
        nv = 8'h40;
        push_n(5, 20);
        repeat (4) cyc();
        chk("conc_start_count", count, 5);
        push_valid = 1'b1;
        pop_ready  = 1'b1;
        for (int k = 0; k < 20; k++) begin
            push_data = DW'(nv);
            cyc();
            if (s_push) nv++;
        end
        push_valid = 1'b0;
        drain(200);

        // asynchronous reset with a read being issued
        nv = 8'h80;
        push_n(8, 30);
        repeat (4) cyc();
        chk("pre_rst_count8", count, 8);
        pop_ready = 1'b1;
        cyc();
        pop_ready = 1'b0;
        #2;
        chk("pre_rst_count7", count, 7);
        chk("pre_rst_read_issue", push_ready, 0);
        rst = 1'b1;
        #1;
        chk("async_rst_pop_valid", pop_valid, 0);
        chk("async_rst_count", count, 0);
        sb.delete();
        m_ram = 0;
        m_ov = 1'b0;
        m_wait = 1'b0;
        last_wr = '0;
        last_rd = '0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst_push_ready", push_ready, 1);
        nv = 8'h11;
        n_pop = 0;
        push_n(1, 5);
        drain(20);
        chk("post_rst_one_pop", n_pop, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
